// File: rtl/msg_encoder_pkg.sv
// NewHope shared constants, state encoding and the message bit ordering.
// The bit ordering must stay identical to the one msg_decoder uses.
package msg_encoder_pkg;

    localparam int NEWHOPE_Q      = 12289;
    localparam int NEWHOPE_HALF_Q = NEWHOPE_Q / 2;
    localparam int NEWHOPE_N      = 512;
    localparam int MSG_BITS       = 256;
    localparam int MSG_WORDS      = 8;

    localparam int COEF_W  = 16;
    localparam int BYTE_AW = $clog2(MSG_WORDS);
    localparam int POLY_AW = $clog2(NEWHOPE_N);

    localparam logic [COEF_W-1:0]  HALF_Q      = COEF_W'(NEWHOPE_HALF_Q);
    localparam logic [POLY_AW-1:0] POLY_OFFSET = POLY_AW'(NEWHOPE_N / 2);
    localparam logic [7:0]         LAST_BIT    = 8'(MSG_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_WR_LO,
        ST_WR_HI
    } enc_state_t;

    // Index into a [0:31] word: byte i[4:3], bit i[2:0] counted from the byte's LSB.
    function automatic logic [4:0] msg_bit_sel(input logic [4:0] bit_idx);
        return {bit_idx[4:3], 3'd7 - bit_idx[2:0]};
    endfunction

endpackage

// File: rtl/msg_encoder_if.sv
// Message RAM read port, polynomial RAM write port and start/busy/done handshake.
interface msg_encoder_if;
    import msg_encoder_pkg::*;

    logic                 start;
    logic                 busy;
    logic                 done;
    logic [BYTE_AW-1:0]   byte_addr;
    logic [0:31]          byte_do;
    logic                 poly_we;
    logic [POLY_AW-1:0]   poly_addr;
    logic [COEF_W-1:0]    poly_di;

    modport master (
        input  start,
        input  byte_do,
        output busy,
        output done,
        output byte_addr,
        output poly_we,
        output poly_addr,
        output poly_di
    );

    modport slave (
        output start,
        output byte_do,
        input  busy,
        input  done,
        input  byte_addr,
        input  poly_we,
        input  poly_addr,
        input  poly_di
    );

endinterface

// File: rtl/msg_encoder.sv
// NewHope poly_frommsg: expands a 256-bit message into 512 coefficients,
// writing poly[i] and poly[i+256] as HALF_Q or 0 for each message bit i.
module msg_encoder
    import msg_encoder_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    msg_encoder_if.master  bus
);

    enc_state_t          state;
    logic [7:0]          i;
    logic [7:0]          i_next;
    logic [0:31]         w;
    logic                cur_bit;
    logic [COEF_W-1:0]   cur_coef;

    logic                busy_r;
    logic                done_r;
    logic [BYTE_AW-1:0]  byte_addr_r;
    logic                poly_we_r;
    logic [POLY_AW-1:0]  poly_addr_r;
    logic [COEF_W-1:0]   poly_di_r;

    assign i_next   = i + 8'd1;
    assign cur_bit  = w[msg_bit_sel(i[4:0])];
    assign cur_coef = cur_bit ? HALF_Q : '0;

    // Outputs lag the state by one cycle, so done appears the cycle after the
    // last write and busy drops on that same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            i           <= '0;
            w           <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            byte_addr_r <= '0;
            poly_we_r   <= 1'b0;
            poly_addr_r <= '0;
            poly_di_r   <= '0;
        end else begin
            busy_r    <= (state != ST_IDLE);
            done_r    <= (state == ST_IDLE) && busy_r;
            poly_we_r <= 1'b0;

            case (state)
                ST_IDLE: begin
                    // busy_r/done_r still high means the last run is finishing.
                    if (bus.start && !busy_r && !done_r) begin
                        i           <= '0;
                        byte_addr_r <= '0;
                        state       <= ST_FETCH;
                    end
                end

                ST_FETCH: begin
                    state <= ST_LOAD;
                end

                ST_LOAD: begin
                    w     <= bus.byte_do;
                    state <= ST_WR_LO;
                end

                ST_WR_LO: begin
                    poly_we_r   <= 1'b1;
                    poly_addr_r <= {1'b0, i};
                    poly_di_r   <= cur_coef;
                    state       <= ST_WR_HI;
                end

                ST_WR_HI: begin
                    poly_we_r   <= 1'b1;
                    poly_addr_r <= {1'b0, i} + POLY_OFFSET;
                    poly_di_r   <= cur_coef;
                    i           <= i_next;
                    if (i == LAST_BIT) begin
                        state <= ST_IDLE;
                    end else if (i[4:0] == 5'd31) begin
                        byte_addr_r <= i_next[7:5];
                        state       <= ST_FETCH;
                    end else begin
                        state <= ST_WR_LO;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.byte_addr = byte_addr_r;
    assign bus.poly_we   = poly_we_r;
    assign bus.poly_addr = poly_addr_r;
    assign bus.poly_di   = poly_di_r;

endmodule
